// File: rtl/data_bus_arbiter.sv
// data_bus_arbiter: two-master round-robin arbiter for the data-side
// req/gnt/rvalid bus. It tracks which master issued each accepted
// transaction, so every in-order slave response goes back to the master
// that issued it. The number of accepted-but-unanswered transactions is
// limited to MAX_OUT.
`timescale 1ns/1ps
module data_bus_arbiter #(
    parameter int MAX_OUT = 2,
    parameter int CNT_W   = $clog2(MAX_OUT + 1)
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             m0_req_i,
    input  logic             m0_we_i,
    input  logic [3:0]       m0_be_i,
    input  logic [31:0]      m0_addr_i,
    input  logic [31:0]      m0_wdata_i,
    output logic             m0_gnt_o,
    output logic             m0_rvalid_o,
    output logic [31:0]      m0_rdata_o,
    input  logic             m1_req_i,
    input  logic             m1_we_i,
    input  logic [3:0]       m1_be_i,
    input  logic [31:0]      m1_addr_i,
    input  logic [31:0]      m1_wdata_i,
    output logic             m1_gnt_o,
    output logic             m1_rvalid_o,
    output logic [31:0]      m1_rdata_o,
    output logic             s_req_o,
    output logic             s_we_o,
    output logic [3:0]       s_be_o,
    output logic [31:0]      s_addr_o,
    output logic [31:0]      s_wdata_o,
    input  logic             s_gnt_i,
    input  logic             s_rvalid_i,
    input  logic [31:0]      s_rdata_i,
    output logic [CNT_W-1:0] outstanding_o,
    output logic             resp_err_o
);

    // Owner FIFO pointer width; a single-entry FIFO still needs a 1-bit pointer.
    localparam int PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;

    logic                 rr_last_r;
    logic [CNT_W-1:0]     count_r;
    logic [MAX_OUT-1:0]   owner_r;
    logic [PTR_W-1:0]     wr_ptr_r;
    logic [PTR_W-1:0]     rd_ptr_r;
    logic                 resp_err_r;

    logic                 full_s;
    logic                 any_req_s;
    logic                 sel_valid_s;
    logic                 sel_id_s;
    logic                 accept_s;
    logic                 pop_s;
    logic                 head_id_s;

    // Advance a FIFO pointer, wrapping at MAX_OUT so depths that are not powers of two work.
    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        if (p == PTR_W'(MAX_OUT - 1)) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // The full check looks only at the registered count, so an rvalid in the
    // same cycle cannot unblock a request: the gnt path stays off the rvalid path.
    assign full_s    = (count_r == CNT_W'(MAX_OUT));
    assign any_req_s = m0_req_i | m1_req_i;
    assign s_req_o   = any_req_s & ~full_s;
    assign accept_s  = s_req_o & s_gnt_i;
    assign pop_s     = s_rvalid_i & (count_r != {CNT_W{1'b0}});
    assign head_id_s = owner_r[rd_ptr_r];
    assign m0_gnt_o  = accept_s & sel_valid_s & ~sel_id_s;
    assign m1_gnt_o  = accept_s & sel_valid_s & sel_id_s;

    assign outstanding_o = count_r;
    assign resp_err_o    = resp_err_r;

    // Master selection: a lone requester wins; on a tie the master not served last wins.
    always_comb begin
        sel_valid_s = 1'b0;
        sel_id_s    = 1'b0;
        if (m0_req_i && m1_req_i) begin
            sel_valid_s = 1'b1;
            sel_id_s    = ~rr_last_r;
        end else if (m0_req_i) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b0;
        end else if (m1_req_i) begin
            sel_valid_s = 1'b1;
            sel_id_s    = 1'b1;
        end else begin
            sel_valid_s = 1'b0;
            sel_id_s    = 1'b0;
        end
    end

    // Slave payload mux: drives the selected master's fields, zeros when nobody is selected.
    always_comb begin
        s_we_o    = 1'b0;
        s_be_o    = 4'h0;
        s_addr_o  = 32'h0000_0000;
        s_wdata_o = 32'h0000_0000;
        if (sel_valid_s) begin
            if (sel_id_s) begin
                s_we_o    = m1_we_i;
                s_be_o    = m1_be_i;
                s_addr_o  = m1_addr_i;
                s_wdata_o = m1_wdata_i;
            end else begin
                s_we_o    = m0_we_i;
                s_be_o    = m0_be_i;
                s_addr_o  = m0_addr_i;
                s_wdata_o = m0_wdata_i;
            end
        end else begin
            s_we_o    = 1'b0;
            s_be_o    = 4'h0;
            s_addr_o  = 32'h0000_0000;
            s_wdata_o = 32'h0000_0000;
        end
    end

    // Response routing: send rvalid/rdata to the owner at the FIFO head; the other master sees zeros.
    always_comb begin
        m0_rvalid_o = 1'b0;
        m1_rvalid_o = 1'b0;
        m0_rdata_o  = 32'h0000_0000;
        m1_rdata_o  = 32'h0000_0000;
        if (pop_s) begin
            if (head_id_s) begin
                m1_rvalid_o = 1'b1;
                m1_rdata_o  = s_rdata_i;
            end else begin
                m0_rvalid_o = 1'b1;
                m0_rdata_o  = s_rdata_i;
            end
        end else begin
            m0_rvalid_o = 1'b0;
            m1_rvalid_o = 1'b0;
        end
    end

    // Round-robin history: remember the last granted master (reset favours master 0).
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rr_last_r <= 1'b1;
        end else if (accept_s) begin
            rr_last_r <= sel_id_s;
        end else begin
            rr_last_r <= rr_last_r;
        end
    end

    // Outstanding counter: +1 on accept, -1 on a valid response, unchanged when both happen.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            count_r <= {CNT_W{1'b0}};
        end else begin
            case ({accept_s, pop_s})
                2'b10:   count_r <= count_r + CNT_W'(1);
                2'b01:   count_r <= count_r - CNT_W'(1);
                default: count_r <= count_r;
            endcase
        end
    end

    // Owner FIFO storage and write pointer: append the accepted master's id at the tail.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            owner_r  <= {MAX_OUT{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
        end else if (accept_s) begin
            owner_r[wr_ptr_r] <= sel_id_s;
            wr_ptr_r          <= ptr_next(wr_ptr_r);
        end else begin
            owner_r  <= owner_r;
            wr_ptr_r <= wr_ptr_r;
        end
    end

    // Owner FIFO read pointer: drop the head entry once its response has been routed.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (pop_s) begin
            rd_ptr_r <= ptr_next(rd_ptr_r);
        end else begin
            rd_ptr_r <= rd_ptr_r;
        end
    end

    // Sticky error flag: set by a response with nothing outstanding; only reset clears it.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            resp_err_r <= 1'b0;
        end else if (s_rvalid_i && (count_r == {CNT_W{1'b0}})) begin
            resp_err_r <= 1'b1;
        end else begin
            resp_err_r <= resp_err_r;
        end
    end

endmodule

// File: tb/tb_data_bus_arbiter.sv
// Self-checking bench for data_bus_arbiter (MAX_OUT=2). A vector table
// drives the main scenarios. An owner scoreboard queue records the
// expected master for each grant and checks response routing. Hand-written
// sequences cover the asynchronous reset during traffic and the stray
// response that follows it.
`timescale 1ns/1ps
module tb_data_bus_arbiter;

    localparam logic [31:0] M0_ADDR  = 32'h0000_0010;
    localparam logic [31:0] M0_WDATA = 32'hCAFE_F00D;
    localparam logic [3:0]  M0_BE    = 4'hF;
    localparam logic [31:0] M1_ADDR  = 32'h0000_0020;
    localparam logic [31:0] M1_WDATA = 32'h1234_5678;
    localparam logic [3:0]  M1_BE    = 4'h3;
    localparam logic [31:0] IDLE_RD  = 32'h0BAD_0000;

    logic        clk;
    logic        rst_i;
    logic        m0_req_i, m1_req_i;
    logic        m0_gnt_o, m1_gnt_o, m0_rvalid_o, m1_rvalid_o;
    logic [31:0] m0_rdata_o, m1_rdata_o;
    logic        s_req_o, s_we_o, s_gnt_i, s_rvalid_i;
    logic [3:0]  s_be_o;
    logic [31:0] s_addr_o, s_wdata_o, s_rdata_i;
    logic [1:0]  outstanding_o;
    logic        resp_err_o;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic        m0;
        logic        m1;
        logic        sg;
        logic        srv;
        logic [31:0] rd;
        logic [1:0]  sel;   // 0 none, 1 master 0, 2 master 1
        logic        g0;
        logic        g1;
        logic        sreq;
        logic [1:0]  outc;
        logic        err;
    } vec_t;

    vec_t tbl[$];
    bit   owner_q[$];

    data_bus_arbiter #(.MAX_OUT(2)) dut (
        .clk_i        (clk),
        .rst_i        (rst_i),
        .m0_req_i     (m0_req_i),
        .m0_we_i      (1'b0),
        .m0_be_i      (M0_BE),
        .m0_addr_i    (M0_ADDR),
        .m0_wdata_i   (M0_WDATA),
        .m0_gnt_o     (m0_gnt_o),
        .m0_rvalid_o  (m0_rvalid_o),
        .m0_rdata_o   (m0_rdata_o),
        .m1_req_i     (m1_req_i),
        .m1_we_i      (1'b1),
        .m1_be_i      (M1_BE),
        .m1_addr_i    (M1_ADDR),
        .m1_wdata_i   (M1_WDATA),
        .m1_gnt_o     (m1_gnt_o),
        .m1_rvalid_o  (m1_rvalid_o),
        .m1_rdata_o   (m1_rdata_o),
        .s_req_o      (s_req_o),
        .s_we_o       (s_we_o),
        .s_be_o       (s_be_o),
        .s_addr_o     (s_addr_o),
        .s_wdata_o    (s_wdata_o),
        .s_gnt_i      (s_gnt_i),
        .s_rvalid_i   (s_rvalid_i),
        .s_rdata_i    (s_rdata_i),
        .outstanding_o(outstanding_o),
        .resp_err_o   (resp_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic m0, input logic m1, input logic sg, input logic srv,
                       input logic [31:0] rd, input logic [1:0] sel, input logic g0,
                       input logic g1, input logic sreq, input logic [1:0] outc,
                       input logic err);
        vec_t v;
        v.m0 = m0; v.m1 = m1; v.sg = sg; v.srv = srv; v.rd = rd; v.sel = sel;
        v.g0 = g0; v.g1 = g1; v.sreq = sreq; v.outc = outc; v.err = err;
        tbl.push_back(v);
    endtask

    task automatic drive(input logic m0, input logic m1, input logic sg,
                         input logic srv, input logic [31:0] rd);
        m0_req_i   = m0;
        m1_req_i   = m1;
        s_gnt_i    = sg;
        s_rvalid_i = srv;
        s_rdata_i  = rd;
    endtask

    task automatic check_idle_outputs(input string tag);
        chk({tag, " s_req"},   {31'd0, s_req_o},     32'd0);
        chk({tag, " gnt0"},    {31'd0, m0_gnt_o},    32'd0);
        chk({tag, " gnt1"},    {31'd0, m1_gnt_o},    32'd0);
        chk({tag, " rvalid0"}, {31'd0, m0_rvalid_o}, 32'd0);
        chk({tag, " rvalid1"}, {31'd0, m1_rvalid_o}, 32'd0);
        chk({tag, " s_addr"},  s_addr_o,             32'd0);
        chk({tag, " out"},     {30'd0, outstanding_o}, 32'd0);
        chk({tag, " err"},     {31'd0, resp_err_o},  32'd0);
    endtask

    initial begin
        vec_t        v;
        bit          has_rsp;
        bit          own;
        logic [31:0] e_addr, e_wdata;
        logic [3:0]  e_be;
        logic        e_we;

        rst_i = 1'b0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);

        // Single m0 read, answered one cycle later
        add(1'b1, 1'b0, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'hDEADBEEF, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        // Both requesting, slave always grants: alternation with in-order responses
        add(1'b1, 1'b1, 1'b1, 1'b0, IDLE_RD,      2'd2, 1'b0, 1'b1, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'hA1A1_0001, 2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b1, 32'hA2A2_0002, 2'd2, 1'b0, 1'b1, 1'b1, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b1, 32'hA3A3_0003, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        // Slave stalls 3 cycles with both requesting: selection held on m0
        add(1'b1, 1'b1, 1'b0, 1'b0, IDLE_RD,      2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, IDLE_RD,      2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 1'b0, 1'b0, IDLE_RD,      2'd1, 1'b0, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b1, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'hB0B0_0000, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        // Delayed responses: two accepts fill the FIFO; blocked even on a same-cycle pop
        add(1'b1, 1'b0, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b1, 1'b0, 1'b1, 2'd0, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b1, 32'hC0C0_0000, 2'd1, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b1, 1'b0, 1'b1, 1'b0, IDLE_RD,      2'd1, 1'b1, 1'b0, 1'b1, 2'd1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'hC1C1_0001, 2'd0, 1'b0, 1'b0, 1'b0, 2'd2, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'hC2C2_0002, 2'd0, 1'b0, 1'b0, 1'b0, 2'd1, 1'b0);
        // Spurious response with nothing outstanding, then sticky error
        add(1'b0, 1'b0, 1'b0, 1'b1, 32'hEEEE_EEEE, 2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, IDLE_RD,      2'd0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1);

        repeat (2) @(posedge clk);
        #1;
        check_idle_outputs("reset");
        rst_i = 1'b1;

        foreach (tbl[i]) begin
            v = tbl[i];
            @(posedge clk);
            #1;
            drive(v.m0, v.m1, v.sg, v.srv, v.rd);
            #3;
            case (v.sel)
                2'd1: begin e_addr = M0_ADDR; e_wdata = M0_WDATA; e_be = M0_BE; e_we = 1'b0; end
                2'd2: begin e_addr = M1_ADDR; e_wdata = M1_WDATA; e_be = M1_BE; e_we = 1'b1; end
                default: begin e_addr = 32'd0; e_wdata = 32'd0; e_be = 4'h0; e_we = 1'b0; end
            endcase
            chk($sformatf("row%0d gnt0", i),    {31'd0, m0_gnt_o},  {31'd0, v.g0});
            chk($sformatf("row%0d gnt1", i),    {31'd0, m1_gnt_o},  {31'd0, v.g1});
            chk($sformatf("row%0d s_req", i),   {31'd0, s_req_o},   {31'd0, v.sreq});
            chk($sformatf("row%0d s_addr", i),  s_addr_o,           e_addr);
            chk($sformatf("row%0d s_wdata", i), s_wdata_o,          e_wdata);
            chk($sformatf("row%0d s_be", i),    {28'd0, s_be_o},    {28'd0, e_be});
            chk($sformatf("row%0d s_we", i),    {31'd0, s_we_o},    {31'd0, e_we});
            chk($sformatf("row%0d out", i),     {30'd0, outstanding_o}, {30'd0, v.outc});
            chk($sformatf("row%0d err", i),     {31'd0, resp_err_o}, {31'd0, v.err});
            // Scoreboard: pop the expected owner for this response before this cycle's grant is pushed
            has_rsp = v.srv && (owner_q.size() > 0);
            own     = 1'b0;
            if (has_rsp) own = owner_q.pop_front();
            chk($sformatf("row%0d rvalid0", i), {31'd0, m0_rvalid_o}, {31'd0, has_rsp && !own});
            chk($sformatf("row%0d rvalid1", i), {31'd0, m1_rvalid_o}, {31'd0, has_rsp && own});
            chk($sformatf("row%0d rdata0", i),  m0_rdata_o, (has_rsp && !own) ? v.rd : 32'd0);
            chk($sformatf("row%0d rdata1", i),  m1_rdata_o, (has_rsp && own) ? v.rd : 32'd0);
            if (v.g0) owner_q.push_back(1'b0);
            if (v.g1) owner_q.push_back(1'b1);
        end

        // Two accepts in flight, then asynchronous reset mid-cycle (last winner was m0)
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, IDLE_RD);
        #3;
        chk("inflight gnt1 first", {31'd0, m1_gnt_o}, 32'd1);
        chk("inflight gnt0 first", {31'd0, m0_gnt_o}, 32'd0);
        @(posedge clk); #1;
        #3;
        chk("inflight gnt0 second", {31'd0, m0_gnt_o}, 32'd1);
        chk("inflight out1", {30'd0, outstanding_o}, 32'd1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, IDLE_RD);
        #2;
        chk("inflight out2", {30'd0, outstanding_o}, 32'd2);
        chk("inflight err held", {31'd0, resp_err_o}, 32'd1);
        rst_i = 1'b0;
        #1;
        check_idle_outputs("async reset");
        owner_q.delete();
        @(posedge clk); #1;
        rst_i = 1'b1;

        // A late response after reset is spurious
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'hFEED_0001);
        #3;
        chk("stray rvalid0", {31'd0, m0_rvalid_o}, 32'd0);
        chk("stray rvalid1", {31'd0, m1_rvalid_o}, 32'd0);
        chk("stray rdata0", m0_rdata_o, 32'd0);
        chk("stray rdata1", m1_rdata_o, 32'd0);
        chk("stray err before edge", {31'd0, resp_err_o}, 32'd0);
        @(posedge clk); #1;
        drive(1'b1, 1'b1, 1'b1, 1'b0, IDLE_RD);
        #3;
        chk("stray err sticky", {31'd0, resp_err_o}, 32'd1);
        chk("post-reset tie gnt0", {31'd0, m0_gnt_o}, 32'd1);
        chk("post-reset tie gnt1", {31'd0, m1_gnt_o}, 32'd0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 1'b0, 1'b0, IDLE_RD);
        #3;
        chk("post-reset out", {30'd0, outstanding_o}, 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/data_bus_arbiter.md
Name: data_bus_arbiter

Overview:
- Two-master, one-slave arbiter for the data-side req/gnt/rvalid bus.
- Shares the single `bus` data port between the core's LSU (master 0) and a DMA engine (master 1).
- Round-robin arbitration; per-transaction owner tracking so each `rvalid`/`rdata` returns to the master that issued it; bounded outstanding transactions.
- Sits between the core/DMA and the `bus` data port; transparent to peripherals and memories.

Parameters:
- MAX_OUT, 2, max accepted-but-unanswered transactions (1..8); owner FIFO depth.
- CNT_W, $clog2(MAX_OUT+1), width of the outstanding counter.

Ports:
- clk_i  in  1  system clock, rising edge.
- rst_i  in  1  asynchronous, active-low reset.
- m0_req_i, m1_req_i  in  1  master request.
- m0_we_i, m1_we_i  in  1  write enable.
- m0_be_i, m1_be_i  in  4  byte enables.
- m0_addr_i, m1_addr_i  in  32  address.
- m0_wdata_i, m1_wdata_i  in  32  write data.
- m0_gnt_o, m1_gnt_o  out  1  request accepted this cycle.
- m0_rvalid_o, m1_rvalid_o  out  1  response valid.
- m0_rdata_o, m1_rdata_o  out  32  read data; 0 when own rvalid low.
- s_req_o  out  1  slave request.
- s_we_o  out  1  muxed write enable.
- s_be_o  out  4  muxed byte enables.
- s_addr_o  out  32  muxed address.
- s_wdata_o  out  32  muxed write data.
- s_gnt_i  in  1  slave accept.
- s_rvalid_i  in  1  slave response valid.
- s_rdata_i  in  32  slave read data.
- outstanding_o  out  CNT_W  in-flight transaction count.
- resp_err_o  out  1  sticky: `s_rvalid_i` seen with no outstanding transaction.

Behaviour:
- Reset (rst_i=0, async):
  - rr_last=1, so master 0 wins the first tie.
  - Owner FIFO emptied; count=0; resp_err_o=0.
  - With no requests, all combinational outputs are 0.
- Full flag: `full = (count == MAX_OUT)`.
- Selection (combinational):
  - Only one master requesting: select it.
  - Both requesting: select `~rr_last`.
  - No request: select none.
- Slave drive:
  - `s_req_o = (m0_req_i | m1_req_i) & ~full`.
  - `s_we/be/addr/wdata` come from the selected master; all zero when none is selected.
- Grant:
  - `mX_gnt_o = selected(X) & s_req_o & s_gnt_i`.
  - At most one gnt per cycle.
  - Combinational path from req to gnt is permitted.
- Accept = `s_req_o & s_gnt_i`. On accept:
  - rr_last <= selected id.
  - Push selected id into the owner FIFO.
  - rr_last changes only on accept.
- Master rule: a master holds req and payload stable until its gnt. The arbiter does not re-evaluate a stalled choice between cycles, apart from the rr_last rule above.
- Response, when `s_rvalid_i=1` and count>0:
  - Pop the FIFO head id.
  - Same cycle, combinational: `m<id>_rvalid_o=1` and `m<id>_rdata_o=s_rdata_i`.
  - The other master's rvalid=0 and rdata=0.
  - Responses are returned in order; the slave is in-order.
- Spurious response, when `s_rvalid_i=1` and count==0:
  - No master rvalid.
  - resp_err_o <= 1, cleared only by reset.
- Counter update: count += accept − pop.
  - Simultaneous accept and pop leaves the count unchanged and keeps FIFO order: pop the head, push the tail.
  - When full, requests are blocked even if a pop occurs the same cycle. This keeps the gnt path free of the rvalid path.
- FIFO storage: MAX_OUT entries × 1 bit; read/write pointers wrap modulo MAX_OUT.
- outstanding_o = count (registered).
- Reset mid-operation: in-flight owner ids are discarded. A late `s_rvalid_i` after reset is treated as spurious (sets resp_err_o). The arbiter does not block it.
- Bus compatibility: with the existing data port (gnt tied 1, rvalid one cycle after req), steady-state throughput is one transaction per cycle and count never exceeds 1.

Test Plan:
- Reset then m0 read 0x0000_0010, slave gnt=1, rvalid next cycle with 0xDEADBEEF → m0_gnt=1 in cycle 0; m0_rvalid=1 and m0_rdata=0xDEADBEEF in cycle 1; m1 outputs 0; outstanding 1→0.
- m0 and m1 both request continuously, slave always grants → grants alternate m0,m1,m0,m1 (m0 first after reset); each rvalid is routed to the matching master in order.
- s_gnt_i=0 for 3 cycles with both requesting → no gnt, selection held, rr_last unchanged; on gnt=1 the selected master is granted once.
- MAX_OUT=2, slave grants but delays rvalid 4 cycles → exactly 2 accepts, then s_req_o=0 and outstanding_o=2; after the first rvalid, the next accept occurs the following cycle.
- s_rvalid_i pulse with no outstanding transaction → no master rvalid; resp_err_o=1 and it stays 1 until rst_i low.
- Assert rst_i=0 with 2 outstanding mid-flight → count=0, rr_last=1, all outputs 0 asynchronously; a subsequent stray rvalid sets resp_err_o.
